// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse; pause freezes, abort cancels.
// Define COUNTDOWN_AUTORELOAD_EN for periodic mode (reload on exhaustion).
module countdown_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, HOLD} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload, reload_nx, count_nx;
  logic             expire_nx;

  assign busy       = (state == RUN) || (state == HOLD);
  assign load_ready = (state == IDLE) || (state == ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      expire <= expire_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    expire_nx = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (load_valid && load_ready) begin
      reload_nx = load_value;
      count_nx  = load_value;
      state_nx  = ARMED;
    end else if (state == ARMED) begin
      if (start) state_nx = RUN;
    end else if (busy) begin
      if (pause) begin
        state_nx = HOLD;
      end else if (count > WIDTH'(1)) begin
        count_nx = count - WIDTH'(1);
        state_nx = RUN;
      end else begin
        // count is 1 or a loaded 0: budget spent
        expire_nx = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (reload != '0) begin
          count_nx = reload;
          state_nx = RUN;
        end else begin
          count_nx = '0;
          state_nx = IDLE;
        end
`else
        count_nx = '0;
        state_nx = IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed literal checks plus a
// per-cycle comparison against a behavioural model under random stimulus.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, load_valid, load_ready, start, pause, abort, busy, expire;
  logic [5:0] load_value, count;

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  countdown_timer #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .start(start), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .expire(expire)
  );

  always #5 clk = ~clk;

  // Behavioural model: armed/counting flags and remaining budget.
  int m_cnt, m_rel;
  bit m_armed, m_counting, m_exp;

  always @(posedge clk or posedge rst) begin : mdl
    int c, r;
    bit a, k, e;
    if (rst) begin
      m_cnt <= 0; m_rel <= 0; m_armed <= 0; m_counting <= 0; m_exp <= 0;
    end else begin
      c = m_cnt; r = m_rel; a = m_armed; k = m_counting; e = 0;
      if (abort) begin
        c = 0; a = 0; k = 0;
      end else if (load_valid && !k) begin
        c = int'(load_value); r = c; a = 1;
      end else if (a) begin
        if (start) begin a = 0; k = 1; end
      end else if (k && !pause) begin
        if (c >= 2) c = c - 1;
        else begin
          e = 1;
          if (AR && r != 0) c = r;
          else begin c = 0; k = 0; end
        end
      end
      m_cnt <= c; m_rel <= r; m_armed <= a; m_counting <= k; m_exp <= e;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(count), m_cnt);
      chk("model_busy", int'(busy), int'(m_counting));
      chk("model_expire", int'(expire), int'(m_exp));
      chk("model_ready", int'(load_ready), int'(!m_counting));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load_valid = 1'b1; load_value = 6'(v);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 0; load_value = '0; start = 0; pause = 0; abort = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_ready", int'(load_ready), 1);
    rst = 1'b0;
    chk_en = 1'b1;

    // load 5 then run to exhaustion
    do_load(5);
    chk("load5_count", int'(count), 5);
    chk("load5_ready", int'(load_ready), 1);
    do_start();
    chk("s5_count", int'(count), 5);
    chk("s5_busy", int'(busy), 1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("run5_count", int'(count), (k < 5) ? 5 - k : (AR ? 5 : 0));
      chk("run5_expire", int'(expire), (k == 5) ? 1 : 0);
    end
    chk("end5_ready", int'(load_ready), AR ? 0 : 1);
    do_abort();

    // load 4 with a 3-cycle pause: expiry after S+7
    do_load(4);
    do_start();
    cyc();
    chk("p4_count1", int'(count), 3);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("p4_frozen", int'(count), 3);
      chk("p4_busy", int'(busy), 1);
    end
    pause = 1'b0;
    cyc(); chk("p4_c2", int'(count), 2);
    cyc(); chk("p4_c1", int'(count), 1); chk("p4_noexp", int'(expire), 0);
    cyc(); chk("p4_exp", int'(expire), 1); chk("p4_c0", int'(count), AR ? 4 : 0);
    do_abort();

    // load 6, abort after 2 decrements
    do_load(6);
    do_start();
    cyc(); cyc();
    chk("ab_count", int'(count), 4);
    do_abort();
    chk("ab_count0", int'(count), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_expire", int'(expire), 0);
    chk("ab_ready", int'(load_ready), 1);

    // load 0: expiry after S+1, always one-shot
    do_load(0);
    do_start();
    chk("z_busy", int'(busy), 1);
    cyc();
    chk("z_expire", int'(expire), 1);
    chk("z_busy0", int'(busy), 0);
    cyc();
    chk("z_expire_once", int'(expire), 0);

    // load while running is ignored
    do_load(4);
    do_start();
    cyc();
    do_load(9);
    chk("ign_count", int'(count), 2);
    do_abort();

    // async reset mid-count
    do_load(8);
    do_start();
    repeat (5) cyc();
    chk("ar_pre", int'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", int'(count), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_expire", int'(expire), 0);
    chk("ar_ready", int'(load_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    if (AR) begin
      // periodic expiry every 3 cycles
      do_load(3);
      do_start();
      for (int k = 1; k <= 9; k++) begin
        cyc();
        chk("per_count", int'(count), 3 - (k % 3));
        chk("per_expire", int'(expire), (k % 3 == 0) ? 1 : 0);
      end
      do_abort();
      chk("per_stop", int'(busy), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      load_valid = ($urandom_range(0, 99) < 25);
      load_value = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 10));
      start      = ($urandom_range(0, 99) < 30);
      pause      = ($urandom_range(0, 99) < 20);
      abort      = ($urandom_range(0, 99) < 3);
      cyc();
    end
    load_valid = 0; start = 0; pause = 0; abort = 0;
    cyc();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that counts toward zero and raises a one-cycle expiry pulse. It complements the free-running up-counter: where the up-counter measures elapsed cycles, this block is loaded with a cycle budget and signals when that budget is spent. It sits beside the up-counter in the timing/sequencing layer and serves as the programmable timeout and interval source for control FSMs.

## Interface
- WIDTH, 6, width of load value, reload register and count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load request; qualifies load_value.
- load_ready  out  1  block accepts a load this cycle.
- load_value  in  WIDTH  cycle budget to load.
- start  in  1  begin counting; sampled only in ARMED.
- pause  in  1  level; freezes count while high.
- abort  in  1  cancel; highest priority.
- count  out  WIDTH  current remaining count (registered).
- busy  out  1  high in RUN or HOLD.
- expire  out  1  one-cycle pulse when budget is exhausted.

## Operation
- States: IDLE, ARMED, RUN, HOLD. Reset: state IDLE, count 0, reload 0, expire 0, busy 0, load_ready 1.
- load_ready = 1 in IDLE and ARMED, 0 in RUN and HOLD. load_valid with load_ready 0 is ignored, with no effect.
- Load handshake (load_valid & load_ready at an edge): reload <= load_value, count <= load_value, state -> ARMED. A load in ARMED overwrites the pending value.
- ARMED: start=1 -> RUN, with count unchanged on that edge. start in IDLE, RUN or HOLD is ignored.
- RUN/HOLD, each edge with abort=0:
  - If pause=0 and count>1: count <= count-1.
  - If pause=0 and count==1: count <= 0, expire <= 1, state -> IDLE.
  - If pause=0 and count==0 (zero was loaded): expire <= 1, state -> IDLE, count stays 0.
  - Next state is HOLD if pause=1, else RUN. While pause=1, count is frozen.
- abort=1 at any edge, in any state: state -> IDLE, count <= 0, expire <= 0. Abort overrides load, start, pause and expiry on the same edge.
- Priority: abort > load > start > pause > decrement.
- expire is registered and high for exactly one cycle per exhaustion. It is never high during reset.
- Count never wraps. The block never decrements from 0.

## Timing
- Load at edge E0: count = load_value and load_ready still 1 after E0.
- Start sampled at edge S with load N≥1: count reaches 0 and expire=1 in the cycle after edge S+N. busy goes high after edge S and low after edge S+N.
- Load of 0: expire pulses after edge S+1.
- Each cycle of pause=1 sampled in RUN/HOLD delays expiry by exactly one cycle.
- Asynchronous rst mid-count: all outputs return to reset values immediately. No expire is generated.

## Configuration
- COUNTDOWN_AUTORELOAD_EN:
  - Defined: on exhaustion with reload≥1, count <= reload (not 0) and the state stays RUN (or HOLD if pause=1). expire still pulses for one cycle, giving a periodic expire every reload cycles. load_ready stays 0 until abort. A reload of 0 behaves as one-shot and returns to IDLE.
  - Undefined: one-shot behaviour as described in Operation.

## Test plan
- Reset, then load 5, start at edge S -> count 5,4,3,2,1,0 on successive edges, expire=1 only after edge S+5, then IDLE with load_ready=1.
- Load 4, start, pause high for 3 cycles mid-count -> expire after edge S+7. Count is frozen during the pause and busy stays 1.
- Load 6, start, abort after 2 decrements -> count 0, busy 0, no expire, load_ready 1 on the next cycle.
- Load 0, start -> expire after edge S+1. Separately, load_valid asserted in RUN -> ignored, and count is unaffected.
- Assert rst asynchronously mid-count (count=3) -> count 0, busy 0, expire 0 immediately, without waiting for a clock edge.
- With COUNTDOWN_AUTORELOAD_EN, load 3 and start -> expire after edges S+3, S+6 and S+9, with count sequence 3,2,1,3,2,1; abort stops it.
